// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - multi-cycle control sequencer with memory stalls, conditional branch and sticky halt
module ctrl_seq #(
   parameter int IW      = 9,
   parameter int OPW     = 3,
   parameter int TGTW    = 3,
   parameter int TGT_LSB = 3,
   parameter int LD_OP   = 4,
   parameter int ST_OP   = 5,
   parameter int BR_OP   = 6,
   parameter int MEM_LAT = 2,
   parameter int BR_COND = 0,
   parameter int CNTW    = 16
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic [IW-1:0]   Instruction,
   input  logic            InstrValid,
   input  logic            Zero,
   output logic            BranchEn,
   output logic [TGTW-1:0] PCTarg,
   output logic            RegWrEn,
   output logic            MemWrEn,
   output logic            MemRdEn,
   output logic            LoadInst,
   output logic            Stall,
   output logic            Ack,
   output logic [CNTW-1:0] InstrCount
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      HALT    = 2'd2
   } state_t;

   localparam logic [OPW-1:0]  LD_CODE   = OPW'(LD_OP);
   localparam logic [OPW-1:0]  ST_CODE   = OPW'(ST_OP);
   localparam logic [OPW-1:0]  BR_CODE   = OPW'(BR_OP);
   localparam logic [OPW-1:0]  OP_ONES   = '1;
   localparam logic [IW-1:0]   HALT_WORD = '1;
   localparam bit              HAS_LAT   = (MEM_LAT != 0);
   // wait_cnt counts the MEMWAIT cycles that still stall; the issue cycle already stalls once
   localparam logic [3:0]      WAIT_INIT = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);
   localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
   localparam bit              BR_ALWAYS = (BR_COND == 0);

   state_t         state;
   logic [OPW-1:0] op_q;
   logic [3:0]     wait_cnt;
   logic [OPW-1:0] opcode;

   logic br_d, rw_d, mw_d, mr_d, li_d, st_d;
   logic retire, go_wait, go_halt;

   assign opcode = Instruction[IW-1:IW-OPW];

   // Mealy decode of strobes plus the intent signals that steer the state register
   always_comb begin
      br_d    = 1'b0;
      rw_d    = 1'b0;
      mw_d    = 1'b0;
      mr_d    = 1'b0;
      li_d    = 1'b0;
      st_d    = 1'b0;
      retire  = 1'b0;
      go_wait = 1'b0;
      go_halt = 1'b0;
      case (state)
         RUN: begin
            if (InstrValid) begin
               if (Instruction == HALT_WORD) begin
                  // halt retires but raises no strobe; Ack follows at the edge
                  retire  = 1'b1;
                  go_halt = 1'b1;
               end else if (opcode == LD_CODE) begin
                  mr_d = 1'b1;
                  li_d = 1'b1;
                  if (HAS_LAT) begin
                     st_d    = 1'b1;
                     go_wait = 1'b1;
                  end else begin
                     rw_d   = 1'b1;
                     retire = 1'b1;
                  end
               end else if (opcode == ST_CODE) begin
                  mw_d = 1'b1;
                  if (HAS_LAT) begin
                     st_d    = 1'b1;
                     go_wait = 1'b1;
                  end else begin
                     retire = 1'b1;
                  end
               end else if (opcode == BR_CODE) begin
                  br_d   = BR_ALWAYS | Zero;
                  retire = 1'b1;
               end else if (opcode == OP_ONES) begin
                  // non-halt encodings under the all-ones opcode are NOPs
                  retire = 1'b1;
               end else begin
                  rw_d   = 1'b1;
                  retire = 1'b1;
               end
            end
         end
         MEMWAIT: begin
            // the held instruction is ignored; the latched opcode drives the decode
            li_d = (op_q == LD_CODE);
            if (wait_cnt != 4'd0) begin
               st_d = 1'b1;
            end else begin
               rw_d   = (op_q == LD_CODE);
               retire = 1'b1;
            end
         end
         HALT: begin
            st_d = 1'b1;
         end
         default: begin
            st_d = 1'b0;
         end
      endcase
   end

   // every combinational output is forced low while reset is asserted
   assign BranchEn = Reset_n & br_d;
   assign RegWrEn  = Reset_n & rw_d;
   assign MemWrEn  = Reset_n & mw_d;
   assign MemRdEn  = Reset_n & mr_d;
   assign LoadInst = Reset_n & li_d;
   assign Stall    = Reset_n & st_d;
   assign PCTarg   = Reset_n ? Instruction[TGT_LSB+TGTW-1:TGT_LSB] : '0;

   // state register, memory wait counter, sticky Ack and retired-instruction counter
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= RUN;
         op_q       <= '0;
         wait_cnt   <= 4'd0;
         Ack        <= 1'b0;
         InstrCount <= '0;
      end else begin
         if (retire) begin
            InstrCount <= InstrCount + CNT_ONE;
         end
         case (state)
            RUN: begin
               if (go_halt) begin
                  state <= HALT;
                  Ack   <= 1'b1;
               end else if (go_wait) begin
                  state    <= MEMWAIT;
                  op_q     <= opcode;
                  wait_cnt <= WAIT_INIT;
               end
            end
            MEMWAIT: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  state <= RUN;
               end
            end
            HALT: begin
               Ack <= 1'b1;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - scoreboard bench for ctrl_seq
module tb_ctrl_seq;

   localparam logic [8:0] ALU  = 9'b000_011_001;
   localparam logic [8:0] LD1  = 9'b100_010_000;
   localparam logic [8:0] LD2  = 9'b100_001_000;
   localparam logic [8:0] ST   = 9'b101_110_000;
   localparam logic [8:0] BR   = 9'b110_101_000;
   localparam logic [8:0] NOPW = 9'b111_000_000;
   localparam logic [8:0] HLT  = 9'b111_111_111;

   logic       Clk;
   logic       Reset_n;
   logic [8:0] instr_a, instr_b;
   logic       valid_a, valid_b, zero_a, zero_b;

   logic       be_a, rw_a, mw_a, mr_a, li_a, st_a, ack_a;
   logic [2:0] pct_a;
   logic [15:0] cnt_a;
   logic       be_b, rw_b, mw_b, mr_b, li_b, st_b, ack_b;
   logic [2:0] pct_b;
   logic [3:0] cnt_b;

   logic [25:0] obs_a, obs_b;
   logic [25:0] qa[$], oa[$], qb[$], ob[$];

   int passed = 0;
   int total  = 0;

   ctrl_seq #(.MEM_LAT(2), .BR_COND(0), .CNTW(16)) dut_a (
      .Clk(Clk), .Reset_n(Reset_n), .Instruction(instr_a), .InstrValid(valid_a), .Zero(zero_a),
      .BranchEn(be_a), .PCTarg(pct_a), .RegWrEn(rw_a), .MemWrEn(mw_a), .MemRdEn(mr_a),
      .LoadInst(li_a), .Stall(st_a), .Ack(ack_a), .InstrCount(cnt_a)
   );

   ctrl_seq #(.MEM_LAT(0), .BR_COND(1), .CNTW(4)) dut_b (
      .Clk(Clk), .Reset_n(Reset_n), .Instruction(instr_b), .InstrValid(valid_b), .Zero(zero_b),
      .BranchEn(be_b), .PCTarg(pct_b), .RegWrEn(rw_b), .MemWrEn(mw_b), .MemRdEn(mr_b),
      .LoadInst(li_b), .Stall(st_b), .Ack(ack_b), .InstrCount(cnt_b)
   );

   assign obs_a = {be_a, rw_a, mw_a, mr_a, li_a, st_a, ack_a, pct_a, cnt_a};
   assign obs_b = {be_b, rw_b, mw_b, mr_b, li_b, st_b, ack_b, pct_b, 12'd0, cnt_b};

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [25:0] mk(input logic be, input logic rw, input logic mw, input logic mr,
                                      input logic li, input logic st, input logic ack,
                                      input logic [2:0] pct, input logic [15:0] cnt);
      return {be, rw, mw, mr, li, st, ack, pct, cnt};
   endfunction

   task automatic apply_a(input logic [8:0] ins, input logic v, input logic z, input logic rn,
                          input logic [25:0] exp);
      @(negedge Clk);
      instr_a = ins; valid_a = v; zero_a = z; Reset_n = rn;
      qa.push_back(exp);
      #2;
      oa.push_back(obs_a);
   endtask

   task automatic apply_b(input logic [8:0] ins, input logic v, input logic z, input logic rn,
                          input logic [25:0] exp);
      @(negedge Clk);
      instr_b = ins; valid_b = v; zero_b = z; Reset_n = rn;
      qb.push_back(exp);
      #2;
      ob.push_back(obs_b);
   endtask

   task automatic test_reset();
      logic [25:0] e, o;
      apply_a(ALU, 1'b1, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,3'd0,16'd0));
      apply_b(HLT, 1'b1, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,3'd0,16'd0));
      apply_b(9'd0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,3'd0,16'd0));
      for (int i = 0; qa.size() != 0; i++) begin
         e = qa.pop_front(); o = oa.pop_front(); total++;
         if (o !== e) $display("FAIL reset_a[%0d]: got %h want %h", i, o, e); else passed++;
      end
      for (int i = 0; qb.size() != 0; i++) begin
         e = qb.pop_front(); o = ob.pop_front(); total++;
         if (o !== e) $display("FAIL reset_b[%0d]: got %h want %h", i, o, e); else passed++;
      end
   endtask

   task automatic test_alu();
      logic [25:0] e, o;
      apply_a(ALU, 1'b1, 1'b0, 1'b1, mk(0,1,0,0,0,0,0,3'b011,16'd0));
      apply_a(9'd0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b000,16'd1));
      for (int i = 0; qa.size() != 0; i++) begin
         e = qa.pop_front(); o = oa.pop_front(); total++;
         if (o !== e) $display("FAIL alu[%0d]: got %h want %h", i, o, e); else passed++;
      end
   endtask

   task automatic test_load();
      logic [25:0] e, o;
      apply_a(LD1, 1'b1, 1'b0, 1'b1, mk(0,0,0,1,1,1,0,3'b010,16'd1));
      apply_a(LD1, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,1,1,0,3'b010,16'd1));
      apply_a(LD1, 1'b1, 1'b0, 1'b1, mk(0,1,0,0,1,0,0,3'b010,16'd1));
      apply_a(9'd0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b000,16'd2));
      for (int i = 0; qa.size() != 0; i++) begin
         e = qa.pop_front(); o = oa.pop_front(); total++;
         if (o !== e) $display("FAIL load[%0d]: got %h want %h", i, o, e); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [25:0] e, o;
      apply_a(LD1, 1'b1, 1'b0, 1'b1, mk(0,0,0,1,1,1,0,3'b010,16'd2));
      apply_a(LD1, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,1,1,0,3'b010,16'd2));
      apply_a(LD1, 1'b1, 1'b0, 1'b1, mk(0,1,0,0,1,0,0,3'b010,16'd2));
      apply_a(LD2, 1'b1, 1'b0, 1'b1, mk(0,0,0,1,1,1,0,3'b001,16'd3));
      apply_a(LD2, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,1,1,0,3'b001,16'd3));
      apply_a(LD2, 1'b1, 1'b0, 1'b1, mk(0,1,0,0,1,0,0,3'b001,16'd3));
      apply_a(9'd0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b000,16'd4));
      for (int i = 0; qa.size() != 0; i++) begin
         e = qa.pop_front(); o = oa.pop_front(); total++;
         if (o !== e) $display("FAIL back_to_back[%0d]: got %h want %h", i, o, e); else passed++;
      end
   endtask

   task automatic test_store();
      logic [25:0] e, o;
      apply_a(ST, 1'b1, 1'b0, 1'b1, mk(0,0,1,0,0,1,0,3'b110,16'd4));
      apply_a(ST, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,1,0,3'b110,16'd4));
      apply_a(ST, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b110,16'd4));
      apply_a(9'd0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b000,16'd5));
      for (int i = 0; qa.size() != 0; i++) begin
         e = qa.pop_front(); o = oa.pop_front(); total++;
         if (o !== e) $display("FAIL store[%0d]: got %h want %h", i, o, e); else passed++;
      end
   endtask

   task automatic test_nop_idle();
      logic [25:0] e, o;
      apply_a(NOPW, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b000,16'd5));
      apply_a(ALU, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b011,16'd6));
      apply_a(9'd0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b000,16'd6));
      for (int i = 0; qa.size() != 0; i++) begin
         e = qa.pop_front(); o = oa.pop_front(); total++;
         if (o !== e) $display("FAIL nop_idle[%0d]: got %h want %h", i, o, e); else passed++;
      end
   endtask

   task automatic test_branch_always();
      logic [25:0] e, o;
      apply_a(BR, 1'b1, 1'b0, 1'b1, mk(1,0,0,0,0,0,0,3'b101,16'd6));
      apply_a(BR, 1'b1, 1'b1, 1'b1, mk(1,0,0,0,0,0,0,3'b101,16'd7));
      apply_a(9'd0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b000,16'd8));
      for (int i = 0; qa.size() != 0; i++) begin
         e = qa.pop_front(); o = oa.pop_front(); total++;
         if (o !== e) $display("FAIL branch_always[%0d]: got %h want %h", i, o, e); else passed++;
      end
   endtask

   task automatic test_branch_cond();
      logic [25:0] e, o;
      apply_b(BR, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b101,16'd0));
      apply_b(BR, 1'b1, 1'b1, 1'b1, mk(1,0,0,0,0,0,0,3'b101,16'd1));
      apply_b(9'd0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b000,16'd2));
      for (int i = 0; qb.size() != 0; i++) begin
         e = qb.pop_front(); o = ob.pop_front(); total++;
         if (o !== e) $display("FAIL branch_cond[%0d]: got %h want %h", i, o, e); else passed++;
      end
   endtask

   task automatic test_zero_latency();
      logic [25:0] e, o;
      apply_b(LD1, 1'b1, 1'b0, 1'b1, mk(0,1,0,1,1,0,0,3'b010,16'd2));
      apply_b(ST, 1'b1, 1'b0, 1'b1, mk(0,0,1,0,0,0,0,3'b110,16'd3));
      apply_b(9'd0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b000,16'd4));
      for (int i = 0; qb.size() != 0; i++) begin
         e = qb.pop_front(); o = ob.pop_front(); total++;
         if (o !== e) $display("FAIL zero_latency[%0d]: got %h want %h", i, o, e); else passed++;
      end
   endtask

   task automatic test_wrap();
      logic [25:0] e, o;
      int cnt = 4;
      for (int k = 0; k < 12; k++) begin
         apply_b(ALU, 1'b1, 1'b0, 1'b1, mk(0,1,0,0,0,0,0,3'b011,16'(cnt)));
         cnt = (cnt + 1) % 16;
      end
      apply_b(9'd0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b000,16'(cnt)));
      for (int i = 0; qb.size() != 0; i++) begin
         e = qb.pop_front(); o = ob.pop_front(); total++;
         if (o !== e) $display("FAIL wrap[%0d]: got %h want %h", i, o, e); else passed++;
      end
   endtask

   task automatic test_halt();
      logic [25:0] e, o;
      apply_a(HLT, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b111,16'd8));
      apply_a(ALU, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,1,1,3'b011,16'd9));
      apply_a(LD1, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,1,1,3'b010,16'd9));
      apply_a(BR,  1'b1, 1'b1, 1'b1, mk(0,0,0,0,0,1,1,3'b101,16'd9));
      for (int i = 0; qa.size() != 0; i++) begin
         e = qa.pop_front(); o = oa.pop_front(); total++;
         if (o !== e) $display("FAIL halt[%0d]: got %h want %h", i, o, e); else passed++;
      end
   endtask

   task automatic test_reset_memwait();
      logic [25:0] e, o;
      apply_a(LD1, 1'b1, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,3'b000,16'd0));
      apply_a(LD1, 1'b1, 1'b0, 1'b1, mk(0,0,0,1,1,1,0,3'b010,16'd0));
      apply_a(LD1, 1'b1, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,3'b000,16'd0));
      apply_a(9'd0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b000,16'd0));
      apply_a(9'd0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b000,16'd0));
      apply_a(ALU, 1'b1, 1'b0, 1'b1, mk(0,1,0,0,0,0,0,3'b011,16'd0));
      apply_a(9'd0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,3'b000,16'd1));
      for (int i = 0; qa.size() != 0; i++) begin
         e = qa.pop_front(); o = oa.pop_front(); total++;
         if (o !== e) $display("FAIL reset_memwait[%0d]: got %h want %h", i, o, e); else passed++;
      end
   endtask

   initial begin
      Reset_n = 1'b0;
      instr_a = 9'd0; valid_a = 1'b0; zero_a = 1'b0;
      instr_b = 9'd0; valid_b = 1'b0; zero_b = 1'b0;
      test_reset();
      test_alu();
      test_load();
      test_back_to_back();
      test_store();
      test_nop_idle();
      test_branch_always();
      test_branch_cond();
      test_zero_latency();
      test_wrap();
      test_halt();
      test_reset_memwait();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Multi-cycle control sequencer for the processor core; a parametrised successor to the combinational control decoder. It decodes each fetched instruction into register-file, data-memory and branch enables. It adds three things the decoder lacks: memory-latency stalls for load/store, an optional Zero-conditioned branch, and a sticky halt Ack. It sits between instruction ROM/fetch unit (Instruction, Stall, BranchEn, PCTarg) and the datapath (RegWrEn, MemWrEn, MemRdEn, LoadInst).

## Interface
- IW, 9: instruction width; opcode = Instruction[IW-1:IW-OPW]
- OPW, 3: opcode width
- TGTW, 3: branch-target field width
- TGT_LSB, 3: LSB of target field; require TGT_LSB+TGTW <= IW-OPW
- LD_OP, 4 / ST_OP, 5 / BR_OP, 6: opcode encodings (zero-extended to OPW)
- MEM_LAT, 2: data-memory wait cycles after issue (0..15)
- BR_COND, 0: 0 = branch always on BR_OP; 1 = branch only when Zero=1
- CNTW, 16: retired-instruction counter width
- Clk  in  1  clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Instruction  in  IW  machine code from instruction ROM
- InstrValid  in  1  Instruction is valid this cycle
- Zero  in  1  ALU zero flag, sampled in branch cycle
- BranchEn  out  1  load PC from PCTarg
- PCTarg  out  TGTW  Instruction[TGT_LSB+TGTW-1:TGT_LSB]
- RegWrEn  out  1  reg-file write strobe
- MemWrEn  out  1  data-memory write strobe
- MemRdEn  out  1  data-memory read request
- LoadInst  out  1  reg-file write data from memory (mux select)
- Stall  out  1  hold PC and Instruction
- Ack  out  1  program done, registered, sticky
- InstrCount  out  CNTW  retired instructions, wraps

## Operation
- States: RUN, MEMWAIT, HALT. Registers: state, op_q (OPW), wait_cnt (4b), Ack, InstrCount.
- While Reset_n low, all outputs are 0. state=RUN, wait_cnt=0, op_q=0.
- RUN, InstrValid=0: all strobes 0, Stall=0, no count.
- RUN, ALU opcode (none of LD/ST/BR/all-ones): RegWrEn=1 for one cycle; retire.
- RUN, LD_OP: MemRdEn=1 and LoadInst=1.
  - MEM_LAT=0: RegWrEn=1 in the same cycle; retire.
  - Otherwise: Stall=1, RegWrEn=0, op_q<=opcode, wait_cnt<=MEM_LAT-1, go to MEMWAIT.
- RUN, ST_OP: MemWrEn=1 in the issue cycle only; RegWrEn=0 always.
  - MEM_LAT=0: retire.
  - Otherwise: Stall=1 and enter MEMWAIT as for a load.
- MEMWAIT: decode from op_q, ignoring Instruction and InstrValid. LoadInst=1 if op_q=LD_OP.
  - wait_cnt!=0: Stall=1, decrement wait_cnt.
  - wait_cnt==0: Stall=0. RegWrEn=1 if op_q=LD_OP. Retire and return to RUN.
- RUN, BR_OP: BranchEn = (BR_COND==0) | Zero; single cycle; retire. PCTarg is driven combinationally in every state.
- RUN, Instruction all ones: retire. Ack<=1 and state<=HALT at the next edge; no strobes in this cycle.
- Other BR-width/unused encodings under opcode all-ones: NOP, retire, no strobes.
- HALT: Stall=1, all strobes 0, Ack=1. Leaves HALT only on reset.
- Retire: InstrCount increments by 1 at that edge, mod 2^CNTW.

## Timing
- Strobes, MemRdEn, LoadInst, Stall and BranchEn are Mealy: combinational from state, op_q, Instruction, InstrValid and Zero. They are valid in the same cycle.
- Ack and InstrCount are registered: one-cycle latency after the deciding edge.
- Load/store occupancy is MEM_LAT+1 cycles.
  - Stall is high for exactly MEM_LAT cycles.
  - A load's RegWrEn is high in the last cycle only.
  - MemWrEn is never high more than one cycle per store.
- Back-to-back loads: the second load issues in the cycle after the first load's final MEMWAIT cycle.
- Reset asserted during MEMWAIT: immediate return to RUN. No pending RegWrEn is ever issued, and the count is not incremented.
- InstrCount at 2^CNTW-1 wraps to 0 on the next retire.

## Test plan
- ALU op 9'b000_011_001, InstrValid=1 -> RegWrEn=1, Stall=0, one cycle; InstrCount 0->1.
- Load 9'b100_xxxxxx with MEM_LAT=2:
  - Cycle 0: MemRdEn=1, LoadInst=1, Stall=1, RegWrEn=0.
  - Cycle 1: Stall=1.
  - Cycle 2: Stall=0, RegWrEn=1, LoadInst=1.
  - InstrCount increments once.
- Store 9'b101_xxxxxx with MEM_LAT=2 -> MemWrEn=1 in cycle 0 only, Stall=1 in cycles 0-1, RegWrEn=0 throughout.
- Branch 9'b110_101_000:
  - BR_COND=1, Zero=0 -> BranchEn=0, PCTarg=3'b101.
  - BR_COND=1, Zero=1 -> BranchEn=1.
  - BR_COND=0 -> BranchEn=1 regardless of Zero.
- Halt 9'b111111111 -> Ack=1 from the next cycle. Stall stays 1 and strobes stay 0 for any later instruction until Reset_n low clears Ack to 0.
- Load issued, Reset_n pulsed low in MEMWAIT -> all outputs 0 immediately. State returns to RUN, no RegWrEn pulse, InstrCount unchanged at 0.
